data_mem_lsu: RTL
=================

Name: data_mem_lsu

Overview:
- Next-generation RV32 data memory. Supports full load/store width: LB/LH/LW/LBU/LHU and SB/SH/SW, with byte-lane write enables and load sign/zero extension.
- Detects misaligned, out-of-range and illegal-size accesses and reports them as errors.
- Uses a registered 1-cycle read, a valid/ready request channel and a single-entry response buffer.
- Sits between the MEM pipeline stage and the word array. The pipeline stalls on req_ready=0.

Parameters:
- MEM_SIZE, 1024, number of 32-bit words; need not be a power of 2.
- ADDR_WIDTH, 32, byte-address width.
- INIT_FILE, "", hex image loaded at elaboration when non-empty; contents otherwise undefined.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid is also high.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32 funct3 size/sign code.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response held in buffer.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  2  error code: 00 ok, 01 misaligned, 10 out of range, 11 illegal funct3.

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid=0, rsp_rdata=0, rsp_err=00.
  - The memory array is not reset.
  - A pending response is discarded.
  - A store accepted in the same cycle as reset assertion is not guaranteed.
- Handshake:
  - req_ready = !rsp_valid || rsp_ready (combinational, no dependence on req_valid).
  - Accept = req_valid && req_ready.
  - At most one request is accepted per cycle.
- Latency:
  - Every accepted request, load or store, produces exactly one response.
  - rsp_valid rises on the edge after accept and holds stable until rsp_ready.
  - Back-to-back throughput is 1 request/cycle while rsp_ready=1.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code -> err 11.
- Word index = req_addr[ADDR_WIDTH-1:2]; byte offset = req_addr[1:0].
- Misaligned rules:
  - Half access with addr[0]=1 -> err 01.
  - Word access with addr[1:0]!=0 -> err 01.
- Out of range: word index >= MEM_SIZE -> err 10.
- Error priority is 11 > 01 > 10.
- Any error:
  - No memory write.
  - rsp_rdata=0.
  - The response is still issued.
- Store:
  - Array written on the accept edge.
  - Byte enables: SB -> lane addr[1:0]; SH -> lanes {addr[1],0} and {addr[1],1}; SW -> all 4 lanes.
  - Write data is replicated across lanes before masking.
  - Response has err 00 and rdata 0.
- Load:
  - The selected lane(s) are shifted to the LSBs.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - The result is captured into the response register at accept.
  - A later store to the same word does not alter a held response.
- Store followed by a load of the same word on the next accepted cycle returns the new data; there is no bypass hazard, because the write lands on the same edge the load would sample.
- Stall: while rsp_valid && !rsp_ready, req_ready=0, nothing is accepted and the array is untouched.

Decomposition:
- Shared package mem_pkg holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Typedef enum logic [1:0] mem_err_e: ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_ILLEGAL.
- One combinational sub-module, mem_lane_align:
  - Inputs: funct3, addr[1:0], wdata, raw read word.
  - Outputs: 4-bit byte enable, replicated write word, extended load data, misalign flag.
- The top level holds the array, the checks, the response register and the handshake.

Test Plan:
- Full-width write and read back: SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata 0xDEADBEEF, err 00, one cycle after accept.
- Sub-word store merges bytes:
  - SB 0x80 @0x13 over 0x00000000 -> word 0x80000000.
  - LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080.
  - SH 0x1234 @0x12 -> word 0x12340000; LH @0x12 -> 0x00001234.
- Misalignment leaves memory intact:
  - LW @0x11 -> err 01, rdata 0.
  - SH @0x13 -> err 01, and LW @0x10 is unchanged.
- Range and illegal size:
  - With MEM_SIZE=1024, LW @0x1000 -> err 10; LW @0xFFC -> err 00.
  - Load funct3=011 -> err 11.
  - Misaligned plus out-of-range -> err 01.
- Backpressure: hold rsp_ready=0 after a load -> rsp_valid and rsp_rdata stable, req_ready=0, a queued SW is not written; release -> SW accepted next cycle.
- Reset mid-operation: assert rst_n=0 while rsp_valid=1 -> rsp_valid, rsp_err and rsp_rdata go to 0 immediately (asynchronous), and memory retains prior data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the RV32 data memory load/store unit.
//   - funct3 size/sign codes for loads and stores
//   - error code enumeration returned on every response
//   - f3_legal(): whether a funct3 code is a legal load or store size
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } mem_err_e;

  // Unsigned variants only exist for loads; stores have no sign to extend.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for sub-word accesses.
// Ports:
//   funct3    in  3   RV32 size/sign code
//   addr_lo   in  2   byte offset within the word
//   wdata     in  32  right-aligned store data
//   raw_word  in  32  word read from the array
//   byte_en   out 4   byte-lane write enables
//   wdata_rep out 32  store data replicated across all lanes
//   load_data out 32  selected lane(s) shifted down and extended
//   misalign  out 1   access not naturally aligned for its size
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and half out of the raw word.
  always_comb begin
    sel_byte = 8'h00;
    case (addr_lo)
      2'd0:    sel_byte = raw_word[7:0];
      2'd1:    sel_byte = raw_word[15:8];
      2'd2:    sel_byte = raw_word[23:16];
      2'd3:    sel_byte = raw_word[31:24];
      default: sel_byte = 8'h00;
    endcase
    // addr_lo[0] set is flagged as misaligned, so only bit 1 selects the half.
    sel_half = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
  end

  // Size-dependent enables, write replication, load extension and alignment.
  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = 32'h0000_0000;
    load_data = 32'h0000_0000;
    misalign  = 1'b0;
    case (funct3)
      F3_B: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        load_data = {{24{sel_byte[7]}}, sel_byte};
      end
      F3_BU: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        load_data = {24'h00_0000, sel_byte};
      end
      F3_H: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        load_data = {{16{sel_half[15]}}, sel_half};
        misalign  = addr_lo[0];
      end
      F3_HU: begin
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        load_data = {16'h0000, sel_half};
        misalign  = addr_lo[0];
      end
      F3_W: begin
        byte_en   = 4'b1111;
        wdata_rep = wdata;
        load_data = raw_word;
        misalign  = (addr_lo != 2'd0);
      end
      default: begin
        byte_en   = 4'b0000;
        wdata_rep = 32'h0000_0000;
        load_data = 32'h0000_0000;
        misalign  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// RV32 data memory with valid/ready request channel and a single-entry
// response register. Loads read the array combinationally and the result is
// captured at accept; stores write the array on the accept edge.
// Ports:
//   clk        in  1           rising-edge clock
//   rst_n      in  1           asynchronous active-low reset
//   req_valid  in  1           request present
//   req_ready  out 1           request may be accepted this cycle
//   req_we     in  1           1 = store, 0 = load
//   req_funct3 in  3           RV32 size/sign code
//   req_addr   in  ADDR_WIDTH  byte address
//   req_wdata  in  32          right-aligned store data
//   rsp_valid  out 1           response held in the buffer
//   rsp_ready  in  1           consumer takes the response
//   rsp_rdata  out 32          extended load data (0 for stores/errors)
//   rsp_err    out 2           00 ok, 01 misaligned, 10 range, 11 illegal
module data_mem_lsu
  import mem_pkg::*;
#(
  parameter int    MEM_SIZE   = 1024,
  parameter int    ADDR_WIDTH = 32,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_err
);

  localparam int IDX_W  = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int WIDX_W = ADDR_WIDTH - 2;
  localparam logic [WIDX_W-1:0] MEM_LIMIT = WIDX_W'(MEM_SIZE);

  logic [31:0] mem [0:MEM_SIZE-1];

  logic [WIDX_W-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              in_range;
  logic [31:0]       raw_word;
  logic [3:0]        byte_en;
  logic [31:0]       wdata_rep;
  logic [31:0]       load_data;
  logic              misalign;
  logic              illegal;
  mem_err_e          req_err;
  mem_err_e          rsp_code;
  logic              accept;
  logic              write_en;

  assign word_idx = req_addr[ADDR_WIDTH-1:2];
  assign in_range = (word_idx < MEM_LIMIT);
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign illegal  = !f3_legal(req_we, req_funct3);

  // A full response buffer frees up exactly when the consumer drains it.
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;
  assign write_en  = accept && req_we && (req_err == ERR_NONE);
  assign rsp_err   = rsp_code;

  // Array read; out-of-range indices never touch the array.
  always_comb begin
    raw_word = 32'h0000_0000;
    if (in_range) begin
      raw_word = mem[mem_idx];
    end else begin
      raw_word = 32'h0000_0000;
    end
  end

  mem_lane_align u_align (
    .funct3    (req_funct3),
    .addr_lo   (req_addr[1:0]),
    .wdata     (req_wdata),
    .raw_word  (raw_word),
    .byte_en   (byte_en),
    .wdata_rep (wdata_rep),
    .load_data (load_data),
    .misalign  (misalign)
  );

  // Error classification: illegal size beats misalignment beats range.
  always_comb begin
    req_err = ERR_NONE;
    if (illegal) begin
      req_err = ERR_ILLEGAL;
    end else if (misalign) begin
      req_err = ERR_MISALIGN;
    end else if (!in_range) begin
      req_err = ERR_RANGE;
    end else begin
      req_err = ERR_NONE;
    end
  end

  // Byte-masked store into the array on the accept edge; array is not reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[mem_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end
    end
  end

  // Response buffer: capture at accept, hold until drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      rsp_code  <= ERR_NONE;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_code  <= req_err;
      rsp_rdata <= (!req_we && (req_err == ERR_NONE)) ? load_data : 32'h0000_0000;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
